regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the core pipeline: NRD async read ports,
//  NWR write ports (e.g. ALU and load writeback), a pending-write scoreboard for hazard detection,
//  and a sequential clear engine that zeroes the array after reset.
//  Sits between decode (reads, issue) and writeback (writes).
// PARAMETERS
//  XLEN  32   data width of each register
//  NREG  32   number of architectural registers; entry 0 is hardwired zero
//  NRD   2    number of read ports
//  NWR   2    number of write ports; a higher index has higher priority
//  AW    $clog2(NREG)  address width (derived, do not override)
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          reset, synchronous, active-high
//  rd_addr_i    in   NRD*AW     read addresses, port k at [k*AW +: AW]
//  rd_data_o    out  NRD*XLEN   read data, combinational
//  wr_en_i      in   NWR        write enables
//  wr_addr_i    in   NWR*AW     write addresses
//  wr_data_i    in   NWR*XLEN   write data
//  issue_en_i   in   1          instruction with destination issued this cycle
//  issue_rd_i   in   AW         destination register of issued instruction
//  busy_o       out  NREG       scoreboard: bit r=1 means a write to r is pending
//  init_done_o  out  1          array clear complete; block accepts traffic
// BEHAVIOUR
//  - Reset: FSM -> CLEAR, clear counter=0, busy_o=0, init_done_o=0. rst asserted mid-operation
//    restarts CLEAR from entry 0 and drops all pending busy bits.
//  - CLEAR: one entry per cycle, regs[cnt]<=0, cnt++. After entry NREG-1 -> READY.
//    init_done_o=1 from the cycle after the last clear write, i.e. NREG cycles after rst deasserts.
//  - In CLEAR: wr_en_i and issue_en_i are ignored; rd_data_o=0 on all ports; busy_o stays 0.
//  - READY write: for each port with wr_en_i=1 and addr!=0, regs[addr]<=data at the clock edge.
//    Writes to entry 0 are dropped. When several ports hit the same address, the highest index wins.
//  - Read: rd_data_o[k]=0 if addr==0, else regs[addr]; see CONFIGURATION for same-cycle forwarding.
//  - Scoreboard next state is computed in this order:
//      1. Writeback on any port clears busy[wr_addr].
//      2. issue_en_i then sets busy[issue_rd_i]. Issue wins over a same-cycle writeback
//         to the same register, so busy stays 1.
//    busy[0] is never set. An issue to an already-busy register keeps it busy (WAW is not an error).
//  - Latency: write-to-read visibility is 1 cycle without bypass, 0 with bypass.
//    busy_o updates 1 cycle after the issue or writeback.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - A read whose addr (!=0) matches an active write port in READY returns that port's wr_data_i
//      in the same cycle. Highest matching port index wins.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return array contents only; written data is visible from the next cycle.
// STRUCTURE
//  Package regfile_pkg:
//    - XLEN_DEF localparam
//    - FSM state enum {ST_CLEAR, ST_READY}
//    - function addr_w(n)=$clog2(n)
//  Sub-module regfile_clear_fsm (inputs clk, rst):
//    - contains the state register and clear counter
//    - outputs clr_we, clr_addr, init_done
//    - regfile_mp muxes the clear write ahead of the user write ports
// TESTING
//  1. rst 1 cycle, NREG=32 -> init_done_o rises exactly 32 cycles after rst deasserts;
//     then every register reads 0.
//  2. Write 0xDEADBEEF to x5 on port 0 -> the next cycle rd_data_o[0] for addr 5 = 0xDEADBEEF.
//     Same cycle: old value (bypass off) or 0xDEADBEEF (bypass on).
//  3. Port 0 writes 0x11 and port 1 writes 0x22 to x7 in the same cycle -> x7 reads 0x22.
//  4. Write 0x1234 to x0 -> x0 still reads 0; busy_o[0] stays 0 after issue_rd_i=0.
//  5. Issue x3, then 2 cycles later write x3 -> busy_o[3]=1 for 2 cycles, then 0.
//     Issue and write x3 in the same cycle -> busy_o[3] stays 1.
//  6. Assert rst at clear count 10, or with busy_o=0x0000_00F0 -> busy_o=0, clear restarts,
//     init_done_o low for another 32 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks entries 0..NREG-1 one per cycle, then reports ready.
// state     | meaning
// ST_CLEAR  | zeroing regs[cnt], user traffic ignored
// ST_READY  | array initialised, normal operation
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  state_t        state, state_next;
  logic [AW-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    init_done  = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt + AW'(1);
        if (cnt == AW'(NREG - 1)) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end
      end
      ST_READY: init_done = 1'b1;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and post-reset clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_rd_i,
  output logic [NREG-1:0]     busy_o,
  output logic                init_done_o
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            ready;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_next;

  regfile_clear_fsm #(.NREG(NREG), .AW(AW)) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (ready)
  );

  assign init_done_o = ready;
  assign busy_o      = busy;

  // Ascending port order makes the last (highest-index) matching write win.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (ready && !rst) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] != '0))
          regs[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;

    assign ra = rd_addr_i[k*AW +: AW];

    always_comb begin
      rd_val = '0;
      if (ready && (ra != '0)) begin
        rd_val = regs[ra];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == ra))
            rd_val = wr_data_i[p*XLEN +: XLEN];
        end
`endif
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = rd_val;
  end

  // Writeback clears first, issue sets afterwards so issue wins on a collision.
  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en_i[p])
        busy_next[wr_addr_i[p*AW +: AW]] = 1'b0;
    end
    if (issue_en_i)
      busy_next[issue_rd_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else if (ready)
      busy <= busy_next;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters); same-cycle read expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr_i = '0;
  logic [63:0] rd_data_o;
  logic [1:0]  wr_en_i = '0;
  logic [9:0]  wr_addr_i = '0;
  logic [63:0] wr_data_i = '0;
  logic        issue_en_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic [31:0] busy_o;
  logic        init_done_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_q [$];

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .issue_en_i  (issue_en_i),
    .issue_rd_i  (issue_rd_i),
    .busy_o      (busy_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_i    = '0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    issue_en_i = 1'b0;
    issue_rd_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    while (!init_done_o && n < 100) begin
      step();
      n++;
    end
    check(nm, 64'(n), 64'd32);
  endtask

  initial begin
    vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
    vecs[2] = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h22};
    vecs[3] = '{2'b10, 5'd0,  32'h5555,     5'd31, 32'hA5A5A5A5, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h0};
    vecs[4] = '{2'b11, 5'd1,  32'h111,      5'd2,  32'h222,      5'd1,  5'd2,  32'h111,      32'h222};
    vecs[5] = '{2'b00, 5'd1,  32'hFFFF,     5'd2,  32'hEEEE,     5'd1,  5'd31, 32'h111,      32'hA5A5A5A5};
    vecs[6] = '{2'b10, 5'd3,  32'h33,       5'd0,  32'h99,       5'd3,  5'd0,  32'h0,        32'h0};
    vecs[7] = '{2'b11, 5'd7,  32'h77,       5'd8,  32'h88,       5'd7,  5'd8,  32'h77,       32'h88};

    step();
    step();
    rst = 1'b0;
    check("rst_init_done", 64'(init_done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    wait_init("init_latency");

    for (int i = 0; i < 16; i++) begin
      rd_addr_i = {5'(2*i+1), 5'(2*i)};
      #1;
      check($sformatf("clr_rd_x%0d", 2*i), 64'(rd_data_o[31:0]), 64'd0);
      check($sformatf("clr_rd_x%0d", 2*i+1), 64'(rd_data_o[63:32]), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      wr_en_i   = vecs[i].we;
      wr_addr_i = {vecs[i].wa1, vecs[i].wa0};
      wr_data_i = {vecs[i].wd1, vecs[i].wd0};
      exp_q.push_back(vecs[i].e0);
      exp_q.push_back(vecs[i].e1);
      step();
      idle();
      rd_addr_i = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_rd0", i), 64'(rd_data_o[31:0]), 64'(exp_q.pop_front()));
      check($sformatf("vec%0d_rd1", i), 64'(rd_data_o[63:32]), 64'(exp_q.pop_front()));
    end

    issue_en_i = 1'b1; issue_rd_i = 5'd3;
    step();
    idle();
    check("busy_issue", 64'(busy_o), 64'h8);
    step();
    check("busy_hold", 64'(busy_o), 64'h8);
    wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd3}; wr_data_i = {32'h0, 32'h3333};
    step();
    idle();
    check("busy_wb", 64'(busy_o), 64'h0);
    issue_en_i = 1'b1; issue_rd_i = 5'd3;
    wr_en_i = 2'b10; wr_addr_i = {5'd3, 5'd0}; wr_data_i = {32'h3434, 32'h0};
    step();
    idle();
    check("busy_issue_wb_same", 64'(busy_o), 64'h8);
    wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd3}; wr_data_i = {32'h0, 32'h3535};
    step();
    idle();
    check("busy_wb2", 64'(busy_o), 64'h0);
    issue_en_i = 1'b1; issue_rd_i = 5'd0;
    step();
    idle();
    check("busy_x0", 64'(busy_o), 64'h0);
    for (int r = 4; r < 9; r++) begin
      issue_en_i = 1'b1;
      issue_rd_i = (r == 8) ? 5'd4 : 5'(r);
      step();
    end
    idle();
    check("busy_f0", 64'(busy_o), 64'hF0);

    do_reset();
    check("rst_busy_drop", 64'(busy_o), 64'd0);
    check("rst_busy_init_done", 64'(init_done_o), 64'd0);
    rd_addr_i = {5'd8, 5'd7};
    #1;
    check("clear_rd_masked", 64'(rd_data_o[31:0]), 64'd0);
    wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd4}; wr_data_i = {32'h0, 32'h4444};
    issue_en_i = 1'b1; issue_rd_i = 5'd4;
    wait_init("init_latency_busy_rst");
    idle();
    check("clear_ignores_issue", 64'(busy_o), 64'd0);
    rd_addr_i = {5'd8, 5'd4};
    #1;
    check("clear_ignores_wr", 64'(rd_data_o[31:0]), 64'd0);
    check("clear_zeroed_x8", 64'(rd_data_o[63:32]), 64'd0);

    do_reset();
    repeat (10) step();
    check("mid_clear_init_done", 64'(init_done_o), 64'd0);
    do_reset();
    check("restart_init_done", 64'(init_done_o), 64'd0);
    wait_init("init_latency_restart");

    wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd5}; wr_data_i = {32'h0, 32'hDEADBEEF};
    rd_addr_i = {5'd0, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rd", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
`else
    check("same_cycle_rd", 64'(rd_data_o[31:0]), 64'h0);
`endif
    step();
    idle();
    check("next_cycle_rd", 64'(rd_data_o[31:0]), 64'hDEADBEEF);

    wr_en_i = 2'b11; wr_addr_i = {5'd9, 5'd9}; wr_data_i = {32'h22, 32'h11};
    rd_addr_i = {5'd9, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_prio", 64'(rd_data_o[63:32]), 64'h22);
`else
    check("same_cycle_prio", 64'(rd_data_o[63:32]), 64'h0);
`endif
    step();
    idle();
    check("next_cycle_prio", 64'(rd_data_o[63:32]), 64'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
